// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table probe: FSM states, row/code
// geometry, and the row-to-code-bit mapping (row 0 lands in the MSB).
package truth_table_pkg;
  localparam int ROWS   = 8;
  localparam int CODE_W = 8;
  localparam int ROW_W  = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  function automatic logic [ROW_W-1:0] code_bit(input logic [ROW_W-1:0] row);
    return ROW_W'(CODE_W - 1) - row;
  endfunction
endpackage

// File: rtl/truth_table_probe_settle_timer.sv
// Loadable down-counter that stops at zero; o_tc flags the last cycle of an interval.
module settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == '0);
endmodule

// File: rtl/truth_table_probe.sv
// Sweeps all 8 input rows of a 3-input gate, sampling its output over a window
// per row, and reports the measured truth-table code plus an instability flag.
module truth_table_probe
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int WINDOW        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              dut_out,
  output logic              in1,
  output logic              in2,
  output logic              in3,
  output logic              busy,
  output logic [CODE_W-1:0] code,
  output logic              unstable,
  output logic              code_valid,
  input  logic              code_ready
);
  // Timer is loaded with interval-1 so it reaches terminal count on the interval's last cycle
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] WINDOW_LD = 8'(WINDOW - 1);

  state_t              r_state, w_next;
  logic [ROW_W-1:0]    r_row;
  logic [CODE_W-1:0]   r_code;
  logic                r_unstable;
  logic                r_code_valid;
  logic                w_load;
  logic [7:0]          w_load_val;
  logic [7:0]          w_count;
  logic                w_tc;
  logic                w_last_row;
  logic                w_first;
  logic [ROW_W-1:0]    w_bit;

  assign w_last_row = (r_row == ROW_W'(ROWS - 1));
  assign w_first    = (w_count == WINDOW_LD);
  assign w_bit      = code_bit(r_row);

  settle_timer #(.CNT_W(8)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_count),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SETTLE;
      SETTLE:  if (abort) w_next = IDLE;
               else if (w_tc) w_next = SAMPLE;
      SAMPLE:  if (abort) w_next = IDLE;
               else if (w_tc) w_next = w_last_row ? DONE : SETTLE;
      DONE:    if (r_code_valid && code_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    {in1, in2, in3} = 3'b000;
    busy            = 1'b0;
    w_load          = 1'b0;
    w_load_val      = SETTLE_LD;
    case (r_state)
      IDLE: w_load = start;
      SETTLE: begin
        {in1, in2, in3} = r_row;
        busy            = 1'b1;
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = WINDOW_LD;
        end
      end
      SAMPLE: begin
        {in1, in2, in3} = r_row;
        busy            = 1'b1;
        w_load          = w_tc && !w_last_row;
      end
      // busy stays up for the single DONE cycle before code_valid rises
      DONE:    busy = !r_code_valid;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row        <= '0;
      r_code       <= '0;
      r_unstable   <= 1'b0;
      r_code_valid <= 1'b0;
    end else begin
      r_code_valid <= (r_state == DONE) && !(r_code_valid && code_ready);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_row      <= '0;
            r_code     <= '0;
            r_unstable <= 1'b0;
          end
        end
        SAMPLE: begin
          if (!abort) begin
            // First sample of the window defines the bit; later ones only flag disagreement
            if (w_first) begin
              r_code[w_bit] <= dut_out;
            end else if (dut_out != r_code[w_bit]) begin
              r_unstable <= 1'b1;
            end
            if (w_tc && !w_last_row) begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign code       = r_code;
  assign unstable   = r_unstable;
  assign code_valid = r_code_valid;
endmodule

// File: tb/tb_truth_table_probe.sv
// Scoreboard bench for truth_table_probe: directed sweeps against modelled gates,
// with a monitor per DUT popping expected results when code_valid appears.
module tb_truth_table_probe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, abort_a, ready_a, dut_out_a;
  logic       in1_a, in2_a, in3_a, busy_a, unst_a, valid_a;
  logic [7:0] code_a;
  logic       start_b, abort_b, ready_b, dut_out_b;
  logic       in1_b, in2_b, in3_b, busy_b, unst_b, valid_b;
  logic [7:0] code_b;

  logic [7:0] gcode_a, gcode_b;
  logic       tog_mode;
  logic       tog = 1'b0;
  int         ecnt = 0;
  logic [2:0] row_a, row_b;

  always @(posedge clk) tog  <= ~tog;
  always @(posedge clk) ecnt <= ecnt + 1;

  assign row_a     = {in1_a, in2_a, in3_a};
  assign row_b     = {in1_b, in2_b, in3_b};
  assign dut_out_a = (tog_mode && row_a == 3'd3) ? tog : gcode_a[3'd7 - row_a];
  assign dut_out_b = gcode_b[3'd7 - row_b];

  truth_table_probe dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .dut_out(dut_out_a),
    .in1(in1_a), .in2(in2_a), .in3(in3_a), .busy(busy_a), .code(code_a),
    .unstable(unst_a), .code_valid(valid_a), .code_ready(ready_a)
  );

  truth_table_probe #(.SETTLE_CYCLES(1), .WINDOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .dut_out(dut_out_b),
    .in1(in1_b), .in2(in2_b), .in3(in3_b), .busy(busy_b), .code(code_b),
    .unstable(unst_b), .code_valid(valid_b), .code_ready(ready_b)
  );

  typedef struct {
    logic [7:0] code;
    logic       unst;
    int         s_edge;
    int         lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 'h%0h, required 'h%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor for the default-parameter instance
  initial begin
    exp_t cur;
    bit   have;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 1'b0;
      end else if (valid_a) begin
        if (!have) begin
          if (q_a.size() == 0) begin
            chk("a_unexpected_valid", 1, 0);
          end else begin
            cur  = q_a.pop_front();
            have = 1'b1;
            chk("a_latency", ecnt - cur.s_edge, cur.lat);
          end
        end
        if (have) begin
          chk("a_code", code_a, cur.code);
          chk("a_unstable", unst_a, cur.unst);
          chk("a_busy_in_done", busy_a, 0);
          if (ready_a) have = 1'b0;
        end
      end
    end
  end

  // Monitor for the SETTLE_CYCLES=1, WINDOW=1 instance
  initial begin
    exp_t cur;
    bit   have;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 1'b0;
      end else if (valid_b) begin
        if (!have) begin
          if (q_b.size() == 0) begin
            chk("b_unexpected_valid", 1, 0);
          end else begin
            cur  = q_b.pop_front();
            have = 1'b1;
            chk("b_latency", ecnt - cur.s_edge, cur.lat);
          end
        end
        if (have) begin
          chk("b_code", code_b, cur.code);
          chk("b_unstable", unst_b, cur.unst);
          if (ready_b) have = 1'b0;
        end
      end
    end
  end

  task automatic start_a_sweep(output int s);
    start_a = 1'b1;
    step();
    s       = ecnt;
    start_a = 1'b0;
  endtask

  task automatic wait_a_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (valid_a && ready_a) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk({name, "_handshake_seen"}, seen, 1);
    step();
    chk({name, "_valid_dropped"}, valid_a, 0);
    chk({name, "_idle_busy"}, busy_a, 0);
  endtask

  task automatic sweep_a(input string name, input logic [7:0] g, input logic [7:0] expc,
                         input logic expu);
    int s;
    gcode_a = g;
    start_a_sweep(s);
    chk({name, "_busy_after_start"}, busy_a, 1);
    q_a.push_back('{code: expc, unst: expu, s_edge: s, lat: 49});
    wait_a_done(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  s;
    bit  seen;
    rst_n    = 1'b0;
    start_a  = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
    start_b  = 1'b0; abort_b = 1'b0; ready_b = 1'b1;
    gcode_a  = 8'h00; gcode_b = 8'h00; tog_mode = 1'b0;
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_code", code_a, 8'h00);
    chk("rst_unstable", unst_a, 0);
    chk("rst_inputs", row_a, 3'b000);
    chk("rst_b_busy", busy_b, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Gate 0x3D with defaults
    sweep_a("g3d", 8'h3D, 8'h3D, 1'b0);

    // Constant-1 gate on the short-timing instance
    gcode_b = 8'hFF;
    start_b = 1'b1;
    step();
    s       = ecnt;
    start_b = 1'b0;
    q_b.push_back('{code: 8'hFF, unst: 1'b0, s_edge: s, lat: 17});
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (valid_b) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("b_valid_seen", seen, 1);
    step();
    chk("b_idle_busy", busy_b, 0);

    // Row 011 toggles every cycle; first window sample is 0, so bit 4 drops to 0
    if (tog == 1'b0) step();
    tog_mode = 1'b1;
    sweep_a("toggle", 8'h3D, 8'h2D, 1'b1);
    tog_mode = 1'b0;

    // Backpressure: code_ready low 10 cycles with a start pulse, then start at handshake
    ready_a = 1'b0;
    gcode_a = 8'h96;
    start_a_sweep(s);
    q_a.push_back('{code: 8'h96, unst: 1'b0, s_edge: s, lat: 49});
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (valid_a) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("hold_valid_seen", seen, 1);
    for (int i = 0; i < 10; i++) begin
      start_a = (i == 3);
      step();
    end
    start_a = 1'b0;
    chk("hold_valid_kept", valid_a, 1);
    chk("hold_not_busy", busy_a, 0);
    start_a = 1'b1;
    ready_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("hold_valid_dropped", valid_a, 0);
    chk("hold_start_ignored", busy_a, 0);
    step();
    step();
    chk("hold_still_idle", busy_a, 0);

    // Abort in row 5 SETTLE
    gcode_a = 8'h5A;
    start_a_sweep(s);
    for (int i = 0; i < 31; i++) step();
    chk("abort_row5_inputs", row_a, 3'b101);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_inputs", row_a, 3'b000);
    chk("abort_valid", valid_a, 0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (valid_a || busy_a) seen = 1'b1;
      step();
    end
    chk("abort_stays_idle", seen, 0);
    sweep_a("after_abort", 8'h5A, 8'h5A, 1'b0);

    // Reset during row 2 SAMPLE; rows 0..2 of a constant-1 gate already captured
    gcode_a = 8'hFF;
    start_a_sweep(s);
    for (int i = 0; i < 17; i++) step();
    chk("mid_sweep_code", code_a, 8'hE0);
    chk("mid_sweep_inputs", row_a, 3'b010);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_code", code_a, 8'h00);
    chk("arst_unstable", unst_a, 0);
    chk("arst_valid", valid_a, 0);
    chk("arst_inputs", row_a, 3'b000);
    step();
    rst_n = 1'b1;
    step();
    sweep_a("after_reset", 8'h3D, 8'h3D, 1'b0);

    step();
    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/truth_table_probe.md
TRUTH_TABLE_PROBE -- requirements
Module: truth_table_probe

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, cycles to wait after driving a row before sampling (legal range 1..255).
REQ-002 SHALL have parameter WINDOW, default 2, consecutive cycles over which dut_out is sampled per row (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request one sweep; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of a sweep in progress.
REQ-007 SHALL have port dut_out  input  1  output of the 3-input logic gate under characterisation.
REQ-008 SHALL have ports in1, in2, in3  output  1 each  drive the gate inputs; in1 is the MSB of the row index.
REQ-009 SHALL have port busy  output  1  high from start acceptance until code_valid or abort.
REQ-010 SHALL have port code  output  8  measured truth-table code.
REQ-011 SHALL have port unstable  output  1  at least one row disagreed within its window; qualified by code_valid.
REQ-012 SHALL have port code_valid  output  1  code and unstable are valid.
REQ-013 SHALL have port code_ready  input  1  consumer accepts the code.

Function
REQ-014 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-015 SHALL leave IDLE when start=1 and enter SETTLE with row=0; busy=1 on the next cycle.
REQ-016 SHALL drive {in1,in2,in3}=row during SETTLE and SAMPLE, and 3'b000 in IDLE and DONE.
REQ-017 SHALL stay in SETTLE for exactly SETTLE_CYCLES cycles per row, then enter SAMPLE.
REQ-018 SHALL stay in SAMPLE for exactly WINDOW cycles per row.
REQ-019 SHALL store the first SAMPLE-cycle value of dut_out into code bit (7-row), so row 000 maps to the MSB and row 111 to the LSB.
REQ-020 SHALL set unstable (sticky for the sweep) if any later sample in a row's window differs from that row's first sample; the stored bit remains the first sample.
REQ-021 SHALL, after the last SAMPLE cycle of rows 0..6, increment row and return to SETTLE; after row 7 it SHALL enter DONE.
REQ-022 SHALL assert code_valid exactly 8*(SETTLE_CYCLES+WINDOW)+1 rising edges after the edge that sampled start=1.
REQ-023 SHALL hold code_valid, code and unstable constant in DONE until code_valid&&code_ready; it SHALL then go to IDLE with code_valid=0 on the following cycle.
REQ-024 SHALL ignore start while busy or in DONE, including start coincident with the code_ready handshake.
REQ-025 SHALL, on abort=1 in SETTLE or SAMPLE, go to IDLE next cycle with busy=0, code_valid=0, and inputs driven to 000; code is not updated further.
REQ-026 SHALL ignore abort in IDLE and DONE.
REQ-027 SHALL clear code and unstable to 0 when start is accepted.

Reset
REQ-028 SHALL, while rst_n=0, force state=IDLE, row=0, timers=0, in1/in2/in3=0, busy=0, code=8'h00, unstable=0, code_valid=0, independent of clk.
REQ-029 SHALL, on reset during a sweep, discard all partial results; the first accepted start after release begins a fresh sweep from row 0.

Structure
REQ-030 SHALL take the state enum, ROWS=8 and CODE_W=8 from shared package truth_table_pkg.
REQ-031 SHALL instantiate one sub-module, settle_timer, a loadable down-counter with a terminal-count flag, used for both the SETTLE and the SAMPLE intervals.

Verification
REQ-032 SHALL cover a gate model for code 0x3D with defaults and code_ready=1: code=8'h3D, unstable=0, code_valid exactly 49 edges after start.
REQ-033 SHALL cover a constant-1 gate with SETTLE_CYCLES=1 and WINDOW=1: code=8'hFF, code_valid 17 edges after start.
REQ-034 SHALL cover dut_out toggling every cycle during the row 011 window with WINDOW=2: unstable=1, and code bit 4 equals the first sample.
REQ-035 SHALL cover code_ready held low 10 cycles with start pulsed meanwhile: code_valid, code and unstable are stable throughout, and the start pulse does not begin a new sweep.
REQ-036 SHALL cover abort asserted in row 5 SETTLE: busy=0 next cycle, inputs=000, no code_valid; a new start then yields a correct code.
REQ-037 SHALL cover rst_n low mid-SAMPLE: all outputs zero immediately; the next sweep's result is unaffected by the interrupted one.
